// File: rtl/bcd_xs3_seq_converter_if.sv
// Start/done handshake and data bus of the BCD <-> excess-3 sequential converter.
// The master requests conversions and the converter implements the slave side.
interface bcd_xs3_seq_converter_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  mode;
  logic [4*DIGITS-1:0]   din;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   dout;
  logic                  err;
  logic [DIGITS-1:0]     err_mask;

  modport master (
    output start, mode, din,
    input  busy, done, dout, err, err_mask
  );

  modport slave (
    input  start, mode, din,
    output busy, done, dout, err, err_mask
  );
endinterface

// File: rtl/bcd_xs3_seq_converter.sv
// Multi-digit BCD <-> excess-3 converter, one digit per clock, least significant digit first.
// Invalid input codes produce 4'hF and set the matching err_mask bit.
module bcd_xs3_seq_converter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  bcd_xs3_seq_converter_if.slave bus
);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [4*DIGITS-1:0]   shift_q;
  logic                  mode_q;
  logic [4*DIGITS-1:0]   dout_q;
  logic [DIGITS-1:0]     err_mask_q;
  logic                  busy_q;
  logic                  done_q;

  logic [3:0]            cur_digit;
  logic [3:0]            conv_digit_d;
  logic                  conv_err_d;

  // The digit under conversion is always the bottom nibble of the shift register.
  assign cur_digit = shift_q[3:0];

  // Invalid codes are forced to 4'hF rather than computed, so nothing ever wraps.
  always_comb begin
    conv_digit_d = 4'hF;
    conv_err_d   = 1'b0;
    if (!mode_q) begin
      if (cur_digit <= 4'd9) conv_digit_d = cur_digit + 4'd3;
      else                   conv_err_d   = 1'b1;
    end else begin
      if (cur_digit >= 4'd3 && cur_digit <= 4'd12) conv_digit_d = cur_digit - 4'd3;
      else                                         conv_err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      mode_q     <= 1'b0;
      dout_q     <= '0;
      err_mask_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shift_q    <= bus.din;
            mode_q     <= bus.mode;
            dout_q     <= '0;
            err_mask_q <= '0;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= CONV;
          end
        end
        CONV: begin
          dout_q[4*idx_q +: 4] <= conv_digit_d;
          err_mask_q[idx_q]    <= conv_err_d;
          shift_q              <= shift_q >> 4;
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dout     = dout_q;
  assign bus.err_mask = err_mask_q;
  assign bus.err      = |err_mask_q;
endmodule

// File: tb/tb_bcd_xs3_seq_converter.sv
// Scoreboard bench for the BCD <-> excess-3 sequential converter: stimulus pushes expected
// results, a monitor pops and compares them on every done pulse.
module tb_bcd_xs3_seq_converter;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  logic [4*DIGITS+DIGITS-1:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_xs3_seq_converter_if #(.DIGITS(DIGITS)) dut_if ();

  bcd_xs3_seq_converter #(.DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endtask

  // Reference model: per-digit rules applied independently to each nibble.
  function automatic logic [4*DIGITS+DIGITS-1:0] ref_word(input logic m, input logic [4*DIGITS-1:0] d);
    logic [4*DIGITS-1:0] o;
    logic [DIGITS-1:0]   e;
    logic [3:0]          v;
    o = '0;
    e = '0;
    for (int i = 0; i < DIGITS; i++) begin
      v = d[4*i +: 4];
      if (!m && v < 4'd10)                  o[4*i +: 4] = v + 4'd3;
      else if (m && v > 4'd2 && v < 4'd13)  o[4*i +: 4] = v - 4'd3;
      else begin
        o[4*i +: 4] = 4'hF;
        e[i]        = 1'b1;
      end
    end
    return {o, e};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    logic [4*DIGITS+DIGITS-1:0] e;
    if (!rst && dut_if.done) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: got done=1 dout=%0h expected no done", dut_if.dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout", 32'(dut_if.dout), 32'(e[4*DIGITS+DIGITS-1:DIGITS]));
        chk("err_mask", 32'(dut_if.err_mask), 32'(e[DIGITS-1:0]));
        chk("err", 32'(dut_if.err), 32'(|e[DIGITS-1:0]));
        $display("txn dout=%04h err_mask=%04b err=%0d", dut_if.dout, dut_if.err_mask, dut_if.err);
      end
    end
  end

  // Issues one conversion, waits for done, checks busy length and that dout is held.
  task automatic run_conv(input logic m, input logic [15:0] d, input logic [15:0] exp_d,
                          input logic [3:0] exp_m, input bit detail);
    int busy_cycles;
    int cyc;
    exp_q.push_back({exp_d, exp_m});
    @(negedge clk);
    dut_if.mode  = m;
    dut_if.din   = d;
    dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
    busy_cycles = 0;
    cyc = 0;
    while (!dut_if.done && cyc < 50) begin
      if (dut_if.busy) busy_cycles++;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      total++;
      $display("FAIL done_timeout: got no done within 50 cycles expected done");
    end else if (detail) begin
      chk("busy_len", 32'(busy_cycles), 32'(DIGITS));
      chk("busy_at_done", 32'(dut_if.busy), 32'd0);
    end
    @(negedge clk);
    if (detail) begin
      chk("done_one_cycle", 32'(dut_if.done), 32'd0);
      chk("dout_held", 32'(dut_if.dout), 32'(exp_d));
    end
  endtask

  initial begin
    logic [4*DIGITS+DIGITS-1:0] r;
    logic [15:0] bcd;
    logic [15:0] xs3;
    logic [15:0] word;
    int          cyc;

    // Reset held with start asserted: no conversion may start.
    dut_if.start = 1'b1;
    dut_if.mode  = 1'b0;
    dut_if.din   = 16'h1234;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_busy", 32'(dut_if.busy), 32'd0);
      chk("rst_done", 32'(dut_if.done), 32'd0);
      chk("rst_dout", 32'(dut_if.dout), 32'd0);
      chk("rst_err", 32'(dut_if.err), 32'd0);
      chk("rst_err_mask", 32'(dut_if.err_mask), 32'd0);
    end
    rst = 1'b0;
    dut_if.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(dut_if.busy), 32'd0);

    // Directed vectors, hand-computed.
    run_conv(1'b0, 16'h1234, 16'h4567, 4'b0000, 1'b1);
    repeat (3) @(negedge clk);
    chk("dout_persist", 32'(dut_if.dout), 32'h4567);
    run_conv(1'b0, 16'h12A9, 16'h45FC, 4'b0010, 1'b1);
    run_conv(1'b0, 16'h0909, 16'h3C3C, 4'b0000, 1'b1);
    run_conv(1'b1, 16'h4567, 16'h1234, 4'b0000, 1'b1);
    run_conv(1'b1, 16'h3C02, 16'h09FF, 4'b0011, 1'b1);

    // start re-asserted with new din during CONV must be ignored.
    exp_q.push_back({16'h4567, 4'b0000});
    @(negedge clk);
    dut_if.mode = 1'b0; dut_if.din = 16'h1234; dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.din = 16'h9999; dut_if.mode = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
    cyc = 0;
    while (!dut_if.done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 50) begin
      total++;
      $display("FAIL ignore_done_timeout: got no done expected done");
    end
    repeat (8) @(negedge clk);
    chk("ignore_dout", 32'(dut_if.dout), 32'h4567);

    // Reset during the second CONV cycle aborts with no done pulse.
    @(negedge clk);
    dut_if.mode = 1'b0; dut_if.din = 16'h1234; dut_if.start = 1'b1;
    @(negedge clk);
    dut_if.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(dut_if.busy), 32'd0);
    chk("abort_done", 32'(dut_if.done), 32'd0);
    chk("abort_dout", 32'(dut_if.dout), 32'd0);
    chk("abort_err_mask", 32'(dut_if.err_mask), 32'd0);
    repeat (DIGITS + 4) @(negedge clk);
    chk("abort_still_idle", 32'(dut_if.busy), 32'd0);

    // Every code in every position, both modes; remaining digits are 5.
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < DIGITS; p++)
        for (int v = 0; v < 16; v++) begin
          word = 16'h5555;
          word[4*p +: 4] = 4'(v);
          r = ref_word(1'(m), word);
          run_conv(1'(m), word, r[19:4], r[3:0], 1'b0);
        end

    // Round trip BCD -> XS3 -> BCD over a strided 0..9999 range including both ends.
    for (int n = 0; n <= 9999; n += 101) begin
      bcd = {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
      xs3 = bcd + 16'h3333;
      run_conv(1'b0, bcd, xs3, 4'b0000, 1'b0);
      run_conv(1'b1, xs3, bcd, 4'b0000, 1'b0);
    end
    run_conv(1'b0, 16'h9999, 16'hCCCC, 4'b0000, 1'b0);
    run_conv(1'b1, 16'hCCCC, 16'h9999, 4'b0000, 1'b0);

    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
